// File: rtl/shared_memory_controller.sv
// Backing store behind the shared cache bus: one request in flight, fixed access latency.
// Optional request statistics are enabled by defining MEMCTRL_STATS_EN.
module shared_memory_controller #(
    parameter int ADDR_BITS   = 11,
    parameter int DATA_BITS   = 16,
    parameter int MEM_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           bus_cmd_in,
    input  logic [ADDR_BITS-1:0] bus_addr_in,
    input  logic [DATA_BITS-1:0] bus_data_in,
    output logic [DATA_BITS-1:0] mem_data,
    output logic                 mem_ready,
    output logic                 mem_busy,
    output logic [15:0]          rd_count,
    output logic [15:0]          wb_count
);
    localparam int IDX_BITS = ADDR_BITS - 1;
    localparam int DEPTH    = 1 << IDX_BITS;
    localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);

    generate
        if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
            $error("MEM_LATENCY must be within 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, HOLD} state_t;

    state_t               state, state_nxt;
    logic [1:0]           cmd_q;
    logic [IDX_BITS-1:0]  idx_q;
    logic [DATA_BITS-1:0] data_q;
    logic [3:0]           lat_cnt;
    logic [DATA_BITS-1:0] mem [DEPTH];

    logic capture, resp_entry, is_flush;
    logic unused_addr_lsb;

    // Byte address bit 0 selects nothing: one word per access.
    assign unused_addr_lsb = bus_addr_in[0];
    assign is_flush        = (cmd_q == 2'b11);
    assign mem_busy        = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        resp_entry = 1'b0;
        case (state)
            IDLE: if (bus_cmd_in != 2'b00) begin
                capture   = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: if (lat_cnt == 4'd0) begin
                resp_entry = 1'b1;
                state_nxt  = RESP;
            end
            RESP:    state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q     <= 2'b00;
            idx_q     <= '0;
            data_q    <= '0;
            lat_cnt   <= 4'd0;
            mem_data  <= '0;
            mem_ready <= 1'b0;
        end else begin
            mem_ready <= resp_entry;
            if (capture) begin
                cmd_q   <= bus_cmd_in;
                idx_q   <= bus_addr_in[ADDR_BITS-1:1];
                data_q  <= bus_data_in;
                lat_cnt <= LAT_INIT;
            end else if (state == ACCESS && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (resp_entry && !is_flush) mem_data <= mem[idx_q];
        end
    end

    // Array is deliberately unreset; a flush cut short by reset never reaches this write.
    always_ff @(posedge clk) begin
        if (resp_entry && is_flush) mem[idx_q] <= data_q;
    end

`ifdef MEMCTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= 16'd0;
            wb_count <= 16'd0;
        end else if (resp_entry) begin
            if (is_flush) begin
                if (wb_count != 16'hFFFF) wb_count <= wb_count + 16'd1;
            end else begin
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
        end
    end
`else
    assign rd_count = 16'd0;
    assign wb_count = 16'd0;
`endif

endmodule

// File: tb/tb_shared_memory_controller.sv
// Randomized + directed bench for shared_memory_controller against a timing/array reference model.
module tb_shared_memory_controller;
    localparam int AB  = 11;
    localparam int DB  = 16;
    localparam int LAT = 4;
`ifdef MEMCTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    bus_cmd_in = 2'b00;
    logic [AB-1:0] bus_addr_in = '0;
    logic [DB-1:0] bus_data_in = '0;
    logic [DB-1:0] mem_data;
    logic          mem_ready, mem_busy;
    logic [15:0]   rd_count, wb_count;

    shared_memory_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bus_cmd_in(bus_cmd_in), .bus_addr_in(bus_addr_in),
        .bus_data_in(bus_data_in), .mem_data(mem_data), .mem_ready(mem_ready),
        .mem_busy(mem_busy), .rd_count(rd_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a request captured at edge c completes at edge c+LAT and
    // the controller is free to accept again from edge c+LAT+3.
    logic [DB-1:0] ref_mem [int];
    int            edge_n = 0;
    bit            act = 0;
    int            cap_e = 0;
    logic [1:0]    cap_cmd;
    int            cap_idx;
    logic [DB-1:0] cap_data;
    logic [DB-1:0] exp_data = '0;
    logic [15:0]   exp_rd = 0, exp_wb = 0;
    bit            exp_ready, exp_busy;

    task automatic step();
        @(posedge clk);
        edge_n++;
        if (!rst) begin
            if (act && edge_n >= cap_e + LAT + 3) act = 0;
            if (!act && bus_cmd_in != 2'b00) begin
                act = 1; cap_e = edge_n; cap_cmd = bus_cmd_in;
                cap_idx = int'(bus_addr_in >> 1); cap_data = bus_data_in;
            end
            if (act && edge_n == cap_e + LAT) begin
                if (cap_cmd == 2'b11) begin
                    ref_mem[cap_idx] = cap_data;
                    if (STATS && exp_wb != 16'hFFFF) exp_wb++;
                end else begin
                    exp_data = ref_mem.exists(cap_idx) ? ref_mem[cap_idx] : exp_data;
                    if (STATS && exp_rd != 16'hFFFF) exp_rd++;
                end
            end
        end
        exp_ready = !rst && act && edge_n == cap_e + LAT;
        exp_busy  = !rst && act && edge_n >= cap_e && edge_n <= cap_e + LAT + 1;
        @(negedge clk);
        chk("ready", 32'(mem_ready), 32'(exp_ready));
        chk("busy",  32'(mem_busy),  32'(exp_busy));
        chk("data",  32'(mem_data),  32'(exp_data));
        chk("rdc",   32'(rd_count),  32'(exp_rd));
        chk("wbc",   32'(wb_count),  32'(exp_wb));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        act = 0; exp_data = '0; exp_rd = 0; exp_wb = 0;
        chk("rst_ready", 32'(mem_ready), 32'd0);
        chk("rst_busy",  32'(mem_busy),  32'd0);
        chk("rst_data",  32'(mem_data),  32'd0);
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && mem_busy; i++) step();
        if (mem_busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // One transaction from idle; returns the data seen on the ready pulse.
    task automatic xact(input logic [1:0] cmd, input logic [AB-1:0] addr,
                        input logic [DB-1:0] data, output logic [DB-1:0] rdata);
        int c;
        bit got;
        wait_idle();
        bus_cmd_in = cmd; bus_addr_in = addr; bus_data_in = data;
        step();
        c = edge_n;
        bus_cmd_in = 2'b00;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = mem_ready;
        end
        if (!got) chk("ready_timeout", 32'd0, 32'd1);
        else      chk("latency", 32'(edge_n - c), 32'(LAT));
        rdata = mem_data;
        wait_idle();
    endtask

    logic [9:0] pool [8] = '{10'h000, 10'h3FF, 10'h082, 10'h155, 10'h2AA, 10'h010, 10'h1F0, 10'h301};

    initial begin
        logic [DB-1:0] rd;
        int rq[$];

        // Reset values
        @(negedge clk);
        chk("init_data",  32'(mem_data),  32'd0);
        chk("init_ready", 32'(mem_ready), 32'd0);
        chk("init_busy",  32'(mem_busy),  32'd0);
        chk("init_rdc",   32'(rd_count),  32'd0);
        chk("init_wbc",   32'(wb_count),  32'd0);
        step(); step();
        rst = 1'b0;
        step();

        // Flush then read back
        xact(2'b11, 11'h104, 16'hBEEF, rd);
        xact(2'b01, 11'h104, 16'h0000, rd);
        chk("beef", 32'(rd), 32'hBEEF);

        // Top word, BusRdX after flush
        xact(2'b11, 11'h7FE, 16'h1234, rd);
        xact(2'b10, 11'h7FE, 16'h0000, rd);
        chk("top_word", 32'(rd), 32'h1234);

        // Continuous BusRd: one capture per idle visit
        bus_cmd_in = 2'b01; bus_addr_in = 11'h104;
        for (int i = 0; i < 30; i++) begin
            step();
            if (mem_ready) rq.push_back(edge_n);
        end
        bus_cmd_in = 2'b00;
        chk("held_pulses", 32'(rq.size()), 32'd4);
        if (rq.size() >= 3) begin
            chk("gap0", 32'(rq[1] - rq[0]), 32'(LAT + 3));
            chk("gap1", 32'(rq[2] - rq[1]), 32'(LAT + 3));
        end
        wait_idle();

        // Reset during ACCESS discards the flush
        xact(2'b11, 11'h000, 16'h5555, rd);
        bus_cmd_in = 2'b11; bus_addr_in = 11'h000; bus_data_in = 16'hAAAA;
        step();
        bus_cmd_in = 2'b00;
        step(); step();
        do_reset(2);
        xact(2'b01, 11'h000, 16'h0000, rd);
        chk("flush_discard", 32'(rd), 32'h5555);

        // Statistics
        do_reset(1);
        xact(2'b01, 11'h104, 16'h0, rd);
        xact(2'b11, 11'h20A, 16'h0F0F, rd);
        xact(2'b10, 11'h20A, 16'h0, rd);
        chk("stat_rd_data", 32'(rd), 32'h0F0F);
        xact(2'b11, 11'h20A, 16'hF0F0, rd);
        xact(2'b01, 11'h7FE, 16'h0, rd);
        chk("rd_count", 32'(rd_count), STATS ? 32'd3 : 32'd0);
        chk("wb_count", 32'(wb_count), STATS ? 32'd2 : 32'd0);
`ifdef MEMCTRL_STATS_EN
        force dut.rd_count = 16'hFFFF;
        exp_rd = 16'hFFFF;
        step();
        release dut.rd_count;
        xact(2'b01, 11'h104, 16'h0, rd);
        chk("rd_saturate", 32'(rd_count), 32'hFFFF);
`endif

        // Randomized traffic over a preloaded address pool
        for (int k = 0; k < 8; k++) xact(2'b11, {pool[k], 1'b0}, 16'($urandom), rd);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                bus_cmd_in  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                bus_addr_in = {pool[$urandom_range(0, 7)], 1'($urandom)};
                bus_data_in = 16'($urandom);
                step();
            end
        end
        bus_cmd_in = 2'b00;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
